// File: rtl/bowling_pkg.sv
// rtl/bowling_pkg.sv - shared score types, constants and converter FSM states
package bowling_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int MAX_SCORE = 300;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3_adj.sv
// rtl/bcd_add3_adj.sv - double-dabble add-3 correction for one BCD nibble
module bcd_add3_adj
  import bowling_pkg::*;
(
  input  bcd_digit_t nib_in,
  output bcd_digit_t nib_out
);

  // A nibble of 5 or more would overflow past 9 after the next shift, so pre-bias it by 3
  assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to 3-digit BCD converter (optional BCD_SCORE_CLAMP_EN)
module bin_to_bcd_seq
  import bowling_pkg::*;
#(
  parameter int BIN_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic             range_err
);

  localparam int                CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);

  state_t           state_q, state_d;
  logic [11:0]      work_q, work_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bcd_digit_t       hund_q, hund_d;
  bcd_digit_t       tens_q, tens_d;
  bcd_digit_t       ones_q, ones_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [11:0]      work_adj;

`ifdef BCD_SCORE_CLAMP_EN
  logic             clamp_q, clamp_d;
  logic             rerr_q, rerr_d;
  logic             in_over;

  assign in_over   = (32'(bin_in) > 32'(MAX_SCORE));
  assign range_err = rerr_q;
`else
  assign range_err = 1'b0;
`endif

  bcd_add3_adj u_adj_ones (.nib_in(work_q[3:0]),  .nib_out(work_adj[3:0]));
  bcd_add3_adj u_adj_tens (.nib_in(work_q[7:4]),  .nib_out(work_adj[7:4]));
  bcd_add3_adj u_adj_hund (.nib_in(work_q[11:8]), .nib_out(work_adj[11:8]));

  // Next-state and next-output computation for the IDLE/SHIFT/FINISH sequence
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BCD_SCORE_CLAMP_EN
    clamp_d = clamp_q;
    rerr_d  = rerr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef BCD_SCORE_CLAMP_EN
          shift_d = in_over ? BIN_W'(MAX_SCORE) : bin_in;
          clamp_d = in_over;
`else
          shift_d = bin_in;
`endif
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {work_d, shift_d} = {work_adj, shift_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        hund_d  = work_q[11:8];
        tens_d  = work_q[7:4];
        ones_d  = work_q[3:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef BCD_SCORE_CLAMP_EN
        rerr_d  = clamp_q;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and datapath registers; reset wins over any start in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_SCORE_CLAMP_EN
      clamp_q <= 1'b0;
      rerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BCD_SCORE_CLAMP_EN
      clamp_q <= clamp_d;
      rerr_q  <= rerr_d;
`endif
    end
  end

  assign hundreds = hund_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
